// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the UART receive front end: state encoding,
// legal oversampling ratios and the prescale word type.
package uart_rx_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    typedef logic [5:0] presc_t;

    localparam presc_t PRESC_8  = 6'd8;
    localparam presc_t PRESC_16 = 6'd16;
    localparam presc_t PRESC_32 = 6'd32;

    function automatic logic presc_legal(input presc_t p);
        return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing: edge counter within a bit, two early samples and a
// 3-sample majority vote decided at the third sample point.
module uart_rx_sampler
    import uart_rx_frame_pkg::*;
(
    input  logic   CLK,
    input  logic   RST,
    input  logic   rx_s,
    input  logic   active,
    input  presc_t prescale,
    output logic   bit_done,
    output logic   sampled_bit_valid,
    output logic   sampled_bit
);

    presc_t edge_cnt;
    logic   samp0;
    logic   samp1;
    presc_t half;

    assign half = prescale >> 1;

    // Counter is held at 0 while idle so the first frame cycle always sees edge_cnt = 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= '0;
            samp0    <= 1'b0;
            samp1    <= 1'b0;
        end else begin
            if (!active || edge_cnt == prescale - 6'd1) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + 6'd1;
            end
            if (active && edge_cnt == half - 6'd1) begin
                samp0 <= rx_s;
            end
            if (active && edge_cnt == half) begin
                samp1 <= rx_s;
            end
        end
    end

    assign bit_done          = active && (edge_cnt == prescale - 6'd1);
    assign sampled_bit_valid = active && (edge_cnt == half + 6'd1);
    assign sampled_bit       = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive front end: synchronises RX_IN, walks the frame and emits
// one-cycle Data_Valid / Par_Err / Stop_Err strobes.
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stop_Err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    rx_state_t              state;
    logic                   armed;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic                   par_bad;
    logic                   par_en_q;
    logic                   par_typ_q;
    presc_t                 presc_q;
    logic                   active;
    logic                   bit_done;
    logic                   sampled_bit_valid;
    logic                   sampled_bit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= RX_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign active = (state != IDLE);

    uart_rx_sampler u_sampler (
        .CLK               (CLK),
        .RST               (RST),
        .rx_s              (rx_s),
        .active            (active),
        .prescale          (presc_q),
        .bit_done          (bit_done),
        .sampled_bit_valid (sampled_bit_valid),
        .sampled_bit       (sampled_bit)
    );

    // A start needs rx_s seen high since entering IDLE, so a held break never restarts.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            armed      <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bad    <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            presc_q    <= PRESC_8;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (armed && !rx_s) begin
                        state     <= START;
                        armed     <= 1'b0;
                        bit_cnt   <= '0;
                        par_bad   <= 1'b0;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        // An illegal ratio falls back to 16 so the counter stays bounded.
                        presc_q   <= presc_legal(Prescale) ? Prescale : PRESC_16;
                    end else if (rx_s) begin
                        armed <= 1'b1;
                    end
                end
                START: begin
                    if (sampled_bit_valid && sampled_bit) begin
                        state <= IDLE;
                    end else if (bit_done) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (sampled_bit_valid) begin
                        shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                    end
                    if (bit_done) begin
                        if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (sampled_bit_valid) begin
                        par_bad <= sampled_bit != ((^shift_reg) ^ par_typ_q);
                    end
                    if (bit_done) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Leave half a bit early so a back-to-back start edge is not missed.
                    if (sampled_bit_valid) begin
                        state <= IDLE;
                        if (!sampled_bit) begin
                            Stop_Err <= 1'b1;
                        end else if (par_bad) begin
                            Par_Err <= 1'b1;
                        end else begin
                            Data_Valid <= 1'b1;
                            P_DATA     <= shift_reg;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomised scoreboard bench for uart_rx_frame: frames are queued with their
// expected outcome and strobe cycle, and a monitor checks each strobe.
module tb_uart_rx_frame;
    import uart_rx_frame_pkg::*;

    localparam int DW = 8;
    // RX_IN low to first START cycle: two synchroniser flops plus the edge detect.
    localparam int LAT = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [5:0]    Prescale;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          Par_Err;
    logic          Stop_Err;

    typedef struct {
        logic [2:0]    kind;
        logic [DW-1:0] data;
        int            when;
    } exp_t;

    exp_t          sbq[$];
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] last_good = '0;

    uart_rx_frame dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stop_Err   (Stop_Err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int pick_presc();
        case ($urandom_range(0, 2))
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    task automatic idle_line(input int n, input logic lvl);
        repeat (n) begin
            @(negedge CLK);
            RX_IN = lvl;
        end
    endtask

    // Drives one frame cycle by cycle; flip_bit >= 0 inverts one sample of that bit.
    task automatic apply_stimulus(input logic [DW-1:0] data, input int p, input logic pe,
                                  input logic pt, input logic par_flip, input logic stop_bit,
                                  input int flip_bit, input int flip_off, input int abort_after);
        logic bits[$];
        exp_t e;
        int   n;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(data[i]);
        if (pe) bits.push_back((^data) ^ pt ^ par_flip);
        bits.push_back(stop_bit);
        @(negedge CLK);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        Prescale = 6'(p);
        if (abort_after == 0) begin
            e.when = cyc + LAT + (DW + 1 + int'(pe)) * p + p / 2 + 2;
            if (!stop_bit) begin
                e.kind = 3'b001;
                e.data = last_good;
            end else if (pe && par_flip) begin
                e.kind = 3'b010;
                e.data = last_good;
            end else begin
                e.kind    = 3'b100;
                e.data    = data;
                last_good = data;
            end
            sbq.push_back(e);
        end
        n = 0;
        for (int k = 0; k < bits.size(); k++) begin
            for (int c = 0; c < p; c++) begin
                if (n > 0) @(negedge CLK);
                RX_IN = (k == flip_bit && c == p / 2 + flip_off) ? ~bits[k] : bits[k];
                if (k == 1 && c == 0) begin
                    PAR_EN   = 1'($urandom_range(0, 1));
                    PAR_TYP  = 1'($urandom_range(0, 1));
                    Prescale = 6'(pick_presc());
                end
                n++;
                if (abort_after > 0 && n == abort_after) return;
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST && (Data_Valid || Par_Err || Stop_Err)) begin
                if (sbq.size() == 0) begin
                    check_output("unexpected_strobe", {29'd0, Data_Valid, Par_Err, Stop_Err}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check_output("strobe_kind", {29'd0, Data_Valid, Par_Err, Stop_Err}, {29'd0, e.kind});
                    check_output("strobe_cycle", cyc, e.when);
                    check_output("p_data", {24'd0, P_DATA}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] b2b[3];
        logic          prev_stop_err;
        int            p;
        int            wait_cnt;
        logic          pe;
        logic          pflip;
        logic          sbit;
        b2b[0] = 8'h01;
        b2b[1] = 8'hFE;
        b2b[2] = 8'h7F;

        RST      = 1'b1;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = 6'd8;
        repeat (3) @(negedge CLK);
        check_output("reset_p_data", {24'd0, P_DATA}, 32'd0);
        check_output("reset_data_valid", {31'd0, Data_Valid}, 32'd0);
        check_output("reset_par_err", {31'd0, Par_Err}, 32'd0);
        check_output("reset_stop_err", {31'd0, Stop_Err}, 32'd0);
        RST = 1'b0;
        idle_line(10, 1'b1);

        $display("[TB] good frame 0xA5, P=8, even parity");
        apply_stimulus(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, 0);
        idle_line(5, 1'b1);

        $display("[TB] parity error frame 0x3C, P=16, odd parity");
        apply_stimulus(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0, 0);
        idle_line(5, 1'b1);

        $display("[TB] stop error 0x81 at P=32, break, then 0x55");
        apply_stimulus(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 0);
        idle_line(3 * 32, 1'b0);
        idle_line(20, 1'b1);
        apply_stimulus(8'h55, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 0);
        idle_line(5, 1'b1);

        $display("[TB] 2-cycle glitch at P=8, then 0x12");
        @(negedge CLK);
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        idle_line(2, 1'b0);
        idle_line(40, 1'b1);
        apply_stimulus(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 0);
        idle_line(5, 1'b1);

        $display("[TB] back-to-back frames at P=16 with one flipped sample each");
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(b2b[i], 16, 1'b0, 1'b0, 1'b0, 1'b1,
                           int'($urandom_range(0, 9)), int'($urandom_range(0, 2)), 0);
        end
        idle_line(5, 1'b1);

        $display("[TB] reset during 0xF0 data bits, then 0x0F");
        apply_stimulus(8'hF0, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 8 * 4);
        RST       = 1'b1;
        RX_IN     = 1'b1;
        last_good = '0;
        repeat (2) @(negedge CLK);
        check_output("midreset_p_data", {24'd0, P_DATA}, 32'd0);
        check_output("midreset_strobes", {29'd0, Data_Valid, Par_Err, Stop_Err}, 32'd0);
        RST = 1'b0;
        idle_line(10, 1'b1);
        apply_stimulus(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 0);
        idle_line(5, 1'b1);

        $display("[TB] randomised frames");
        prev_stop_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            p     = pick_presc();
            pe    = 1'($urandom_range(0, 1));
            pflip = pe && ($urandom_range(0, 3) == 0);
            sbit  = ($urandom_range(0, 7) != 0);
            idle_line(prev_stop_err ? int'($urandom_range(2, 6)) : int'($urandom_range(0, 3)), 1'b1);
            apply_stimulus(8'($urandom), p, pe, 1'($urandom_range(0, 1)), pflip, sbit,
                           ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1,
                           int'($urandom_range(0, 2)), 0);
            prev_stop_err = !sbit;
        end
        idle_line(10, 1'b1);

        wait_cnt = 0;
        while (sbq.size() != 0 && wait_cnt < 2000) begin
            @(negedge CLK);
            wait_cnt++;
        end
        check_output("scoreboard_drained", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
UART receive front end. Converts the serial RX line into byte strobes for the clock-domain data synchroniser, which feeds the system controller's command decoder (RX_P_DATA/RX_D_VLD path). It runs on the oversampled UART clock, recovers start/data/parity/stop bits by 3-sample majority vote, and reports parity and framing errors.

Parameters:
DATA_WIDTH, 8, data bits per frame, sent LSB first.
SYNC_STAGES, 2, flops in the RX_IN metastability synchroniser.

Ports:
CLK  in  1  oversampled UART clock; frequency = Prescale x baud.
RST  in  1  asynchronous, active-high reset.
RX_IN  in  1  serial line; idles high.
PAR_EN  in  1  1 = frame carries a parity bit.
PAR_TYP  in  1  0 = even parity, 1 = odd parity.
Prescale  in  6  oversampling ratio; legal values 8, 16, 32.
P_DATA  out  DATA_WIDTH  last good received byte.
Data_Valid  out  1  one-cycle strobe; P_DATA is new.
Par_Err  out  1  one-cycle strobe; parity mismatch.
Stop_Err  out  1  one-cycle strobe; stop bit sampled low.

Behaviour:
- Reset: FSM goes to IDLE. Counters, samples and P_DATA reset to 0. Data_Valid, Par_Err and Stop_Err reset to 0. Synchroniser flops reset to 1. Reset mid-frame abandons the frame with no strobes.
- Input path: RX_IN passes through SYNC_STAGES flops to give rx_s. All logic uses only rx_s.
- Configuration latch: PAR_EN, PAR_TYP and Prescale are captured on entry to START. Changes mid-frame take effect on the next frame.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a 1->0 transition of rx_s. The first START cycle is F, and edge_cnt = 0 at F.
- edge_cnt runs 0..P-1 within each bit, then wraps to 0 and advances the bit.
- Sampling: samples are taken at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the three, decided at edge_cnt = P/2+1.
- START: if the decided bit is 1 (glitch), return to IDLE on the next cycle with no strobes. Otherwise continue to DATA at the bit wrap.
- DATA: shift decided bits into a shift register, LSB first. bit_cnt runs 0..DATA_WIDTH-1. After the last bit, go to PARITY if PAR_EN = 1, else STOP.
- PARITY: compute expected = XOR of the data bits, XOR PAR_TYP. Set a par_bad flag if the decided bit differs from expected.
- STOP: at the decision point, exactly one outcome is registered, and the strobe goes high on the next cycle:
  - stop bit = 0 -> Stop_Err. Stop_Err takes priority; Par_Err is suppressed.
  - par_bad -> Par_Err.
  - otherwise -> Data_Valid, with P_DATA loaded from the shift register on the same edge.
- The FSM returns to IDLE at the STOP decision point, half a bit early, so back-to-back frames with no idle gap are received.
- Strobe timing: strobes are high for exactly one CLK cycle. The strobe cycle is F + (DATA_WIDTH + 1 + PAR_EN)*P + P/2 + 2.
- P_DATA holds its value until the next good frame. It is not updated on an errored frame.
- A line held low after a Stop_Err (break) is not a new start. IDLE waits for rx_s = 1 before arming edge detection.
- Illegal Prescale values (not 8, 16 or 32): behaviour is undefined. The bench does not drive them.

Decomposition:
- Shared package/header: state encoding localparams (IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4) and legal prescale constants (PRESC_8, PRESC_16, PRESC_32).
- One sub-module: uart_rx_sampler.
  - Contents: edge_cnt, the two sample registers, and the majority vote.
  - Outputs: bit_done (at the wrap) and sampled_bit_valid/sampled_bit (at the decision point) to the top-level FSM.
- Top level: FSM, bit counter, shift register, parity check and output registers.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0; send 0xA5 with parity bit 0 and stop bit 1 -> Data_Valid pulses once, 89 cycles after RX_IN first goes low; P_DATA=0xA5; no error strobes.
- Prescale=16, PAR_EN=1, PAR_TYP=1; send 0x3C with parity bit 0 (wrong; odd parity needs 1) -> Par_Err one-cycle pulse; Data_Valid stays 0; P_DATA keeps its previous value.
- Prescale=32, PAR_EN=0; send 0x81 with stop bit 0 -> Stop_Err pulse; no Data_Valid. Then hold the line low for 3 bit times, release, and send 0x55 -> exactly one Data_Valid with 0x55.
- Prescale=8; drive a 2-cycle low glitch on an idle line -> FSM returns to IDLE; no strobes. A following valid 0x12 frame is received correctly.
- Prescale=16, PAR_EN=0; send 0x01, 0xFE, 0x7F back-to-back with no idle gap -> three Data_Valid pulses in order; a single flipped sample inside the vote window of each bit is corrected by the majority vote.
- Assert RST during the DATA bits of a 0xF0 frame, then deassert and send 0x0F -> no strobes for the aborted frame; outputs read 0 during reset; 0x0F is received correctly.
